// File: rtl/mesi_directory_agent_if.sv
// Coherence bus between the two cores and the MESI directory agent.
// slave = the agent, master = the (externally serialised) core side.
interface mesi_directory_agent_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_core;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_block;

    logic              snp_valid;
    logic              snp_ready;
    logic              snp_core;
    logic              snp_op;
    logic [ADDR_W-1:0] snp_block;
    logic              snp_ack_valid;
    logic              snp_ack_dirty;

    logic              rsp_valid;
    logic              rsp_core;
    logic [ADDR_W-1:0] rsp_block;
    logic [1:0]        rsp_state;
    logic              rsp_wb;

    modport slave (
        input  req_valid, req_core, req_op, req_block,
        output req_ready,
        output snp_valid, snp_core, snp_op, snp_block,
        input  snp_ready, snp_ack_valid, snp_ack_dirty,
        output rsp_valid, rsp_core, rsp_block, rsp_state, rsp_wb
    );

    modport master (
        output req_valid, req_core, req_op, req_block,
        input  req_ready,
        input  snp_valid, snp_core, snp_op, snp_block,
        output snp_ready, snp_ack_valid, snp_ack_dirty,
        input  rsp_valid, rsp_core, rsp_block, rsp_state, rsp_wb
    );
endinterface

// File: rtl/mesi_directory_agent.sv
// Two-core MESI directory: one request at a time, optional snoop of the other
// core, directory written only in the response cycle.
module mesi_directory_agent #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    mesi_directory_agent_if.slave  bus,
    output logic                   busy_o
);
    localparam int unsigned NumBlocks = 2 ** ADDR_W;

    localparam logic [1:0] MesiM = 2'b00;
    localparam logic [1:0] MesiE = 2'b01;
    localparam logic [1:0] MesiS = 2'b10;
    localparam logic [1:0] MesiI = 2'b11;

    localparam logic [1:0] OpGets = 2'b00;
    localparam logic [1:0] OpGetm = 2'b01;
    localparam logic [1:0] OpPutm = 2'b10;
    localparam logic [1:0] OpPuts = 2'b11;

    typedef enum logic [2:0] {StIdle, StLookup, StSnoop, StWaitAck, StRespond} state_e;

    state_e state_q, state_d;

    logic              core_q;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] block_q;
    logic              dirty_q;
    // Indexed [block][core].
    logic [NumBlocks-1:0][1:0][1:0] dir_q;

    logic [1:0] req_st, oth_st, grant, oth_new;
    logic       need_snp, wb_nosnp;

    // Directory is stable from LOOKUP to RESPOND, so the decode holds throughout.
    always_comb begin
        req_st   = dir_q[block_q][core_q];
        oth_st   = dir_q[block_q][~core_q];
        need_snp = 1'b0;
        grant    = MesiI;
        oth_new  = oth_st;
        wb_nosnp = 1'b0;
        case (op_q)
            OpGets: begin
                if (req_st != MesiI) begin
                    grant = req_st;
                end else if (oth_st == MesiM || oth_st == MesiE) begin
                    need_snp = 1'b1;
                    grant    = MesiS;
                    oth_new  = MesiS;
                end else if (oth_st == MesiS) begin
                    grant = MesiS;
                end else begin
                    grant = MesiE;
                end
            end
            OpGetm: begin
                grant = MesiM;
                if (oth_st != MesiI) begin
                    need_snp = 1'b1;
                    oth_new  = MesiI;
                end
            end
            OpPutm: wb_nosnp = (req_st == MesiM);
            OpPuts: wb_nosnp = 1'b0;
            default: grant = MesiI;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (bus.req_valid) state_d = StLookup;
            StLookup:  state_d = need_snp ? StSnoop : StRespond;
            StSnoop:   if (bus.snp_ready) state_d = StWaitAck;
            StWaitAck: if (bus.snp_ack_valid) state_d = StRespond;
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_q  <= 1'b0;
            op_q    <= 2'b00;
            block_q <= '0;
            dirty_q <= 1'b0;
            for (int b = 0; b < NumBlocks; b++) begin
                dir_q[b] <= {MesiI, MesiI};
            end
        end else begin
            if (state_q == StIdle && bus.req_valid) begin
                core_q  <= bus.req_core;
                op_q    <= bus.req_op;
                block_q <= bus.req_block;
                dirty_q <= 1'b0;
            end
            if (state_q == StWaitAck && bus.snp_ack_valid) begin
                dirty_q <= bus.snp_ack_dirty;
            end
            if (state_q == StRespond) begin
                dir_q[block_q][core_q]  <= grant;
                dir_q[block_q][~core_q] <= oth_new;
            end
        end
    end

    always_comb begin
        bus.req_ready = (state_q == StIdle) && rst_ni;
        busy_o        = (state_q != StIdle);
        bus.snp_valid = 1'b0;
        bus.snp_core  = 1'b0;
        bus.snp_op    = 1'b0;
        bus.snp_block = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_core  = 1'b0;
        bus.rsp_block = '0;
        bus.rsp_state = 2'b00;
        bus.rsp_wb    = 1'b0;
        if (state_q == StSnoop) begin
            bus.snp_valid = 1'b1;
            bus.snp_core  = ~core_q;
            bus.snp_op    = (op_q == OpGetm);
            bus.snp_block = block_q;
        end
        if (state_q == StRespond) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_core  = core_q;
            bus.rsp_block = block_q;
            bus.rsp_state = grant;
            bus.rsp_wb    = need_snp ? dirty_q : wb_nosnp;
        end
    end
endmodule

// File: tb/tb_mesi_directory_agent.sv
// Randomised and directed bench for mesi_directory_agent against a
// rule-level MESI model of a two-core directory.
module tb_mesi_directory_agent;
    localparam int unsigned AW = 4;
    localparam int M = 0, E = 1, S = 2, I = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    always #5 clk = ~clk;

    mesi_directory_agent_if #(.ADDR_W(AW)) bus ();

    mesi_directory_agent #(.ADDR_W(AW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .busy_o (busy)
    );

    int total = 0;
    int bad   = 0;
    int dir_m [16][2];

    task automatic model_clear();
        for (int b = 0; b < 16; b++) begin
            dir_m[b][0] = I;
            dir_m[b][1] = I;
        end
    endtask

    // Applies the MESI rules and returns what the agent must answer.
    task automatic model_req(input int c, input int op, input int blk, input int dirty,
                             output bit snp, output int sop, output int st, output int wb);
        int me, ot;
        me = dir_m[blk][c];
        ot = dir_m[blk][1-c];
        snp = 0; sop = 0; wb = 0; st = I;
        case (op)
            0: begin
                if (me != I) st = me;
                else if (ot == I) st = E;
                else if (ot == S) st = S;
                else begin snp = 1; sop = 0; st = S; dir_m[blk][1-c] = S; wb = dirty; end
            end
            1: begin
                st = M;
                if (ot != I) begin snp = 1; sop = 1; dir_m[blk][1-c] = I; wb = dirty; end
            end
            2: begin st = I; wb = (me == M) ? 1 : 0; end
            default: st = I;
        endcase
        dir_m[blk][c] = st;
    endtask

    task automatic run_txn(input int c, input int op, input int blk, input int dirty,
                           input int hold_in, input int ack_dly,
                           output int o_state, output int o_wb);
        bit esnp, got, saw, taken, sent;
        int esop, est, ewb, t, cyc, acnt, hold;
        model_req(c, op, blk, dirty, esnp, esop, est, ewb);
        hold = hold_in; got = 0; saw = 0; taken = 0; sent = 0; cyc = 0; acnt = 0;
        o_state = -1; o_wb = -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_core  = c[0];
        bus.req_op    = op[1:0];
        bus.req_block = blk[AW-1:0];
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL accept: req_ready=%b required 1", bus.req_ready);
        end
        @(posedge clk); #1 bus.req_valid = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk); cyc++;
            bus.snp_ack_valid = 1'b0;
            if (taken && !sent) begin
                if (acnt == ack_dly) begin
                    bus.snp_ack_valid = 1'b1;
                    bus.snp_ack_dirty = dirty[0];
                    sent = 1;
                end
                acnt++;
            end
            if (saw && !taken) begin
                total++;
                if (bus.snp_valid !== 1'b1) begin
                    bad++; $display("FAIL snp_hold: snp_valid=%b required 1", bus.snp_valid);
                end
            end
            if (bus.snp_valid === 1'b1) begin
                saw = 1;
                total++;
                if (bus.snp_core !== ~c[0] || bus.snp_op !== esop[0] ||
                    bus.snp_block !== blk[AW-1:0]) begin
                    bad++;
                    $display("FAIL snp_fields: core=%b op=%b blk=%0d required %b %b %0d",
                             bus.snp_core, bus.snp_op, bus.snp_block, ~c[0], esop[0], blk);
                end
                if (hold > 0) begin bus.snp_ready = 1'b0; hold--; end
                else begin bus.snp_ready = 1'b1; taken = 1; end
            end else begin
                bus.snp_ready = 1'b0;
            end
            if (bus.rsp_valid === 1'b1) begin
                got = 1;
                o_state = int'(bus.rsp_state);
                o_wb = int'(bus.rsp_wb);
                total++;
                if (bus.rsp_core !== c[0] || bus.rsp_block !== blk[AW-1:0] ||
                    bus.rsp_state !== est[1:0] || bus.rsp_wb !== ewb[0]) begin
                    bad++;
                    $display("FAIL rsp: core=%b blk=%0d st=%0d wb=%b required %b %0d %0d %b",
                             bus.rsp_core, bus.rsp_block, bus.rsp_state, bus.rsp_wb,
                             c[0], blk, est, ewb[0]);
                end
                if (!esnp) begin
                    total++;
                    if (cyc != 2) begin
                        bad++; $display("FAIL rsp_latency: cycle=%0d required 2", cyc);
                    end
                end
            end
        end
        bus.snp_ready = 1'b0;
        bus.snp_ack_valid = 1'b0;
        total++;
        if (!got) begin bad++; $display("FAIL rsp_timeout: no rsp_valid required one"); end
        total++;
        if (saw != esnp) begin
            bad++; $display("FAIL snp_presence: saw=%0d required %0d", saw, esnp);
        end
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, bus.rsp_core, bus.rsp_block, bus.rsp_state, bus.rsp_wb} !== '0) begin
            bad++; $display("FAIL rsp_idle_zero: rsp_valid=%b state=%0d required all 0",
                            bus.rsp_valid, bus.rsp_state);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (bus.req_ready !== 1'b0 || bus.snp_valid !== 1'b0 || bus.rsp_valid !== 1'b0 ||
            busy !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: ready=%b snp=%b rsp=%b busy=%b required 0",
                            bus.req_ready, bus.snp_valid, bus.rsp_valid, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_release: ready=%b busy=%b required 1 0",
                            bus.req_ready, busy);
        end
        model_clear();
    endtask

    task automatic test_directed();
        int s, w;
        run_txn(0, 0, 3, 0, 0, 0, s, w);
        total++;
        if (s != E || w != 0) begin bad++; $display("FAIL d_gets_e: st=%0d wb=%0d required 1 0", s, w); end
        run_txn(1, 0, 3, 1, 0, 0, s, w);
        total++;
        if (s != S || w != 1) begin bad++; $display("FAIL d_gets_s: st=%0d wb=%0d required 2 1", s, w); end
        run_txn(0, 1, 3, 0, 3, 1, s, w);
        total++;
        if (s != M || w != 0) begin bad++; $display("FAIL d_getm: st=%0d wb=%0d required 0 0", s, w); end
        run_txn(0, 2, 3, 0, 0, 0, s, w);
        total++;
        if (s != I || w != 1) begin bad++; $display("FAIL d_putm: st=%0d wb=%0d required 3 1", s, w); end
        run_txn(1, 0, 3, 0, 0, 0, s, w);
        total++;
        if (s != E || w != 0) begin bad++; $display("FAIL d_gets_after: st=%0d wb=%0d required 1 0", s, w); end
    endtask

    task automatic test_random();
        int s, w;
        for (int n = 0; n < 80; n++) begin
            run_txn(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), s, w);
        end
    endtask

    task automatic test_reset_midtxn();
        int s, w, t;
        run_txn(1, 0, 9, 0, 0, 0, s, w);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_core = 1'b0; bus.req_op = 2'b00; bus.req_block = 4'd9;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (bus.snp_valid !== 1'b1 && t < 10);
        bus.snp_ready = 1'b1;
        @(negedge clk); bus.snp_ready = 1'b0;
        total++;
        if (busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL wait_ack_busy: busy=%b rsp=%b required 1 0", busy, bus.rsp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.snp_valid !== 1'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0 ||
            bus.req_ready !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: snp=%b rsp=%b busy=%b ready=%b required 0",
                            bus.snp_valid, bus.rsp_valid, busy, bus.req_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        model_clear();
        bus.snp_ack_valid = 1'b1; bus.snp_ack_dirty = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 2) bus.snp_ack_valid = 1'b0;
            total++;
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL late_ack: rsp=%b busy=%b required 0 0", bus.rsp_valid, busy);
            end
        end
        run_txn(0, 0, 9, 0, 0, 0, s, w);
        total++;
        if (s != E) begin bad++; $display("FAIL dir_cleared: st=%0d required 1", s); end
    endtask

    task automatic test_back_to_back();
        int s, w;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_core = 1'b0; bus.req_op = 2'b00; bus.req_block = 4'd12;
        @(posedge clk); #1 bus.req_op = 2'b11;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_busy: ready=%b busy=%b required 0 1", bus.req_ready, busy);
        end
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_state !== 2'b01 || bus.req_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_first: rsp=%b st=%0d ready=%b required 1 1 0",
                            bus.rsp_valid, bus.rsp_state, bus.req_ready);
        end
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_idle: ready=%b rsp=%b required 1 0", bus.req_ready, bus.rsp_valid);
        end
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_state !== 2'b11 || bus.rsp_wb !== 1'b0 ||
            bus.rsp_block !== 4'd12) begin
            bad++; $display("FAIL b2b_second: rsp=%b st=%0d wb=%b blk=%0d required 1 3 0 12",
                            bus.rsp_valid, bus.rsp_state, bus.rsp_wb, bus.rsp_block);
        end
        dir_m[12][0] = I;
        run_txn(1, 0, 12, 0, 0, 0, s, w);
        total++;
        if (s != E) begin bad++; $display("FAIL b2b_after: st=%0d required 1", s); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_core = 1'b0; bus.req_op = 2'b00; bus.req_block = '0;
        bus.snp_ready = 1'b0; bus.snp_ack_valid = 1'b0; bus.snp_ack_dirty = 1'b0;
        model_clear();
        test_reset();
        test_directed();
        test_random();
        test_reset_midtxn();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mesi_directory_agent.md
MESI_DIRECTORY_AGENT -- requirements
Module: mesi_directory_agent

Interface
REQ-001 Parameter ADDR_W, default 4, block-index width; the directory holds NUM_BLOCKS = 2**ADDR_W entries.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 req_valid  in  1  a core coherence request is present.
REQ-005 req_ready  out  1  the agent accepts a request this cycle.
REQ-006 req_core  in  1  requesting core, 0 or 1.
REQ-007 req_op  in  2  00 GETS (read miss), 01 GETM (write miss/upgrade), 10 PUTM (evict modified), 11 PUTS (evict clean).
REQ-008 req_block  in  ADDR_W  block index.
REQ-009 snp_valid  out  1  a snoop to the other core is pending.
REQ-010 snp_ready  in  1  the snooped core takes the snoop.
REQ-011 snp_core / snp_op / snp_block  out  1 / 1 / ADDR_W  target core; 0 = downgrade to S, 1 = invalidate; block index.
REQ-012 snp_ack_valid / snp_ack_dirty  in  1 / 1  snoop done; the snooped core's copy was modified.
REQ-013 rsp_valid  out  1  one-cycle response pulse, no back-pressure.
REQ-014 rsp_core / rsp_block / rsp_state / rsp_wb  out  1 / ADDR_W / 2 / 1  requester; block; granted MESI state; memory writeback occurred.
REQ-015 busy  out  1  FSM not in IDLE.

Function
REQ-016 MESI encoding SHALL be M=00, E=01, S=10, I=11; each directory entry SHALL hold one 2-bit state per core.
REQ-017 Invariant: if either core holds M or E for a block, the other core SHALL hold I for that block.
REQ-018 FSM states SHALL be IDLE, LOOKUP, SNOOP, WAIT_ACK and RESPOND; req_ready SHALL be 1 only in IDLE.
REQ-019 On req_valid&&req_ready the agent SHALL register core, op and block, then go IDLE->LOOKUP.
REQ-020 LOOKUP SHALL go to SNOOP if a snoop is required, else to RESPOND.
REQ-021 With no snoop, rsp_valid SHALL be high exactly in the second cycle after the accepting edge, then the FSM returns to IDLE.
REQ-022 SNOOP: snp_valid SHALL stay high with stable fields until snp_ready=1, then go to WAIT_ACK.
REQ-023 WAIT_ACK: on snp_ack_valid, the agent SHALL capture snp_ack_dirty and go to RESPOND; snp_ack_valid SHALL be ignored in other states.
REQ-024 GETS with the other core in I: grant E to the requester if the requester is I; no snoop.
REQ-025 GETS with the other core in S: grant S; no snoop.
REQ-026 GETS with the other core in E/M: snoop downgrade; other core set to S; requester granted S; rsp_wb = ack_dirty.
REQ-027 GETS with the requester already in S/E/M: respond with its current state unchanged; no snoop.
REQ-028 GETM with the other core in I: grant M; requester E->M is a silent upgrade.
REQ-029 GETM with the other core in S/E/M: snoop invalidate; other core set to I; requester granted M; rsp_wb = ack_dirty.
REQ-030 PUTM / PUTS: requester set to I; rsp_state = I; rsp_wb = 1 only for PUTM when the requester was M; no snoop.
REQ-031 An E holder may have silently gone to M, so ack_dirty=1 on an E owner SHALL set rsp_wb=1.
REQ-032 The directory SHALL be updated in the RESPOND cycle only; rsp fields SHALL be 0 whenever rsp_valid=0.
REQ-033 A request presented while busy SHALL be held by the requester, not dropped by the agent; the two cores' requests SHALL be externally serialized onto this single port.

Reset
REQ-034 reset=0 SHALL asynchronously set FSM=IDLE, all directory entries to I/I, all outputs to 0 except req_ready=1 once reset=1.
REQ-035 Reset during SNOOP/WAIT_ACK SHALL drop the transaction with no rsp_valid; a later ack SHALL be ignored.

Verification
REQ-036 Reset; core0 GETS block 3 -> rsp_valid 2 cycles later, rsp_state=01 (E), rsp_wb=0, no snp_valid.
REQ-037 Then core1 GETS block 3, ack_dirty=1 -> snp to core1? No: snp_core=0, snp_op=0; rsp core1 state=10 (S), rsp_wb=1; block 3 = S/S.
REQ-038 Then core0 GETM block 3 -> snp_core=1, snp_op=1; hold snp_ready=0 for 3 cycles, snp_valid stays 1; ack_dirty=0 -> rsp state=00 (M), rsp_wb=0; block 3 = M/I.
REQ-039 core0 PUTM block 3 -> rsp_state=11, rsp_wb=1, no snoop; a following core1 GETS -> E.
REQ-040 Reset asserted in WAIT_ACK -> outputs 0, directory all I; ack after release causes no rsp_valid; req_valid held while busy is accepted only on return to IDLE.
